// File: rtl/retro_bram_arbiter.sv
// Round-robin arbiter sharing one single-port byte-write BRAM, with lock support and read-data routing.
// Optional: define RETRO_BRAM_ARB_PRIO0_EN to give requester 0 absolute priority while unlocked.
module retro_bram_arbiter #(
    parameter int NumInitiators   = 3,
    parameter int AddressBusWidth = 12,
    parameter int DataBusWidth    = 1,
    parameter int MaxLockCycles   = 16
) (
    input  logic                                      Clk,
    input  logic                                      Reset_n,
    input  logic [NumInitiators-1:0]                  ReqAccess,
    input  logic [NumInitiators*DataBusWidth-1:0]     ReqWrite,
    input  logic [NumInitiators*AddressBusWidth-1:0]  ReqAddress,
    input  logic [NumInitiators*8*DataBusWidth-1:0]   ReqDin,
    input  logic [NumInitiators-1:0]                  ReqLock,
    output logic [NumInitiators-1:0]                  ReqReady,
    output logic [NumInitiators-1:0]                  ReqDataReady,
    output logic [8*DataBusWidth-1:0]                 ReqDout,
    output logic                                      BramAccess,
    output logic [DataBusWidth-1:0]                   BramWrite,
    output logic [AddressBusWidth-1:0]                BramAddress,
    output logic [8*DataBusWidth-1:0]                 BramDin,
    input  logic [8*DataBusWidth-1:0]                 BramDout
);

    localparam int IdxW = $clog2(NumInitiators);
    localparam int DinW = 8 * DataBusWidth;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                       state;
    logic [IdxW-1:0]              ptr;
    logic [IdxW-1:0]              owner;
    logic [7:0]                   lock_cnt;
    logic [NumInitiators-1:0]     read_tag;
    logic [AddressBusWidth-1:0]   addr_hold;
    logic [DinW-1:0]              din_hold;

    logic                         grant_valid;
    logic [IdxW-1:0]              grant_idx;
    logic [NumInitiators-1:0]     grant_onehot;
    logic [DataBusWidth-1:0]      grant_write;
    logic [AddressBusWidth-1:0]   grant_addr;
    logic [DinW-1:0]              grant_din;
    logic                         prio0;
    logic                         release_lock;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == IdxW'(NumInitiators - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        int              cand;
        logic [IdxW-1:0] cand_idx;
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        cand        = 0;
        cand_idx    = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
`ifdef RETRO_BRAM_ARB_PRIO0_EN
        prio0 = ReqAccess[0];
`else
        prio0 = 1'b0;
`endif
        if (Reset_n) begin
            if (state == LOCKED) begin
                grant_valid = ReqAccess[owner];
                grant_idx   = owner;
            end else if (prio0) begin
                grant_valid = 1'b1;
                grant_idx   = '0;
            end else begin
                // Scan from the far end so the requester closest to ptr is the last writer and wins.
                for (int k = NumInitiators - 1; k >= 0; k--) begin
                    cand = int'(ptr) + k;
                    if (cand >= NumInitiators) cand = cand - NumInitiators;
                    cand_idx = IdxW'(cand);
                    if (ReqAccess[cand_idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = cand_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        grant_write  = '0;
        grant_addr   = '0;
        grant_din    = '0;
        for (int i = 0; i < NumInitiators; i++) begin
            if (grant_valid && grant_idx == IdxW'(i)) begin
                grant_onehot[i] = 1'b1;
                grant_write     = ReqWrite[i*DataBusWidth +: DataBusWidth];
                grant_addr      = ReqAddress[i*AddressBusWidth +: AddressBusWidth];
                grant_din       = ReqDin[i*DinW +: DinW];
            end
        end
    end

    // While locked the owner is granted whenever it requests, so a dropped lock bit covers both
    // "last access granted" and "idle owner let go"; the timeout ends the lock regardless.
    assign release_lock = !ReqLock[owner] || (lock_cnt >= 8'(MaxLockCycles));

    assign ReqReady     = grant_onehot;
    assign BramAccess   = grant_valid;
    assign BramWrite    = grant_write;
    assign BramAddress  = grant_valid ? grant_addr : addr_hold;
    assign BramDin      = grant_valid ? grant_din  : din_hold;
    assign ReqDataReady = read_tag;
    assign ReqDout      = BramDout;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ARB;
            ptr       <= '0;
            owner     <= '0;
            lock_cnt  <= '0;
            read_tag  <= '0;
            // NOTE: the hold registers are ordinary flops rather than a memory array, so they take a reset.
            addr_hold <= '0;
            din_hold  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            read_tag <= (grant_valid && grant_write == '0) ? grant_onehot : '0;
            if (grant_valid) begin
                addr_hold <= grant_addr;
                din_hold  <= grant_din;
            end
            case (state)
                ARB: begin
                    if (grant_valid) begin
                        if (ReqLock[grant_idx]) begin
                            state    <= LOCKED;
                            owner    <= grant_idx;
                            lock_cnt <= 8'd1;
                        end else begin
                            ptr <= next_idx(grant_idx);
                        end
                    end
                end
                LOCKED: begin
                    if (release_lock) begin
                        state    <= ARB;
                        ptr      <= next_idx(owner);
                        lock_cnt <= '0;
                    end else if (lock_cnt != 8'hFF) begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule
